// File: rtl/extend_reduce.sv
// Retires one batch of extend-lane results one lane per cycle: writes each live
// lane's offset into the wavefront BRAM and tracks the furthest offset and tile-end reach.
module extend_reduce #(
  parameter int NUM_EXTEND    = 8,
  parameter int TILE_SIZE     = 512,
  parameter int LOG_TILE_SIZE = $clog2(TILE_SIZE),
  parameter int TB_ADDR       = 10,
  parameter int LANE_WIDTH    = 2*LOG_TILE_SIZE+TB_ADDR+2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             batch_valid,
  input  logic [NUM_EXTEND*LANE_WIDTH-1:0] batch_data,
  input  logic [NUM_EXTEND-1:0]            lane_valid,
  output logic                             batch_ready,
  input  logic [LOG_TILE_SIZE:0]           target_k,
  input  logic [LOG_TILE_SIZE-1:0]         target_offset,
  input  logic                             clear,
  output logic                             wf_wen,
  output logic [TB_ADDR-1:0]               wf_addr,
  output logic [LOG_TILE_SIZE-1:0]         wf_din,
  output logic [LOG_TILE_SIZE-1:0]         max_offset,
  output logic                             reach_end,
  output logic [TB_ADDR-1:0]               reach_tbaddr,
  output logic                             batch_done
);

  localparam int IDX_W = (NUM_EXTEND > 1) ? $clog2(NUM_EXTEND) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_EXTEND-1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [NUM_EXTEND*LANE_WIDTH-1:0] data_q;
  logic [NUM_EXTEND-1:0]            valid_q;
  logic [IDX_W-1:0]                 idx;

  logic [LANE_WIDTH-1:0]    lane_word;
  logic                     lane_is_valid;
  logic [LOG_TILE_SIZE:0]   lane_k;
  logic [LOG_TILE_SIZE-1:0] lane_offset;
  logic [TB_ADDR-1:0]       lane_tbaddr;
  logic                     lane_live;
  logic                     accept;
  logic                     lane_hits_target;

  // Lane word layout, MSB first: {is_valid, k, offset, tbaddr}
  always_comb begin
    lane_word     = data_q[int'(idx)*LANE_WIDTH +: LANE_WIDTH];
    lane_tbaddr   = lane_word[TB_ADDR-1:0];
    lane_offset   = lane_word[TB_ADDR +: LOG_TILE_SIZE];
    lane_k        = lane_word[TB_ADDR+LOG_TILE_SIZE +: LOG_TILE_SIZE+1];
    lane_is_valid = lane_word[LANE_WIDTH-1];
  end

  assign accept           = (state == IDLE) && batch_valid;
  assign lane_live        = (state == SCAN) && valid_q[idx] && lane_is_valid;
  assign lane_hits_target = (lane_k == target_k) && (lane_offset >= target_offset);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next  = state;
    batch_ready = 1'b0;
    case (state)
      IDLE: begin
        batch_ready = 1'b1;
        if (batch_valid) state_next = SCAN;
      end
      SCAN:    if (idx == LAST_IDX) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The batch is captured on accept so upstream is free to move on immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= '0;
      idx     <= '0;
    end else if (accept) begin
      data_q  <= batch_data;
      valid_q <= lane_valid;
      idx     <= '0;
    end else if (state == SCAN) begin
      idx <= idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wf_wen     <= 1'b0;
      wf_addr    <= '0;
      wf_din     <= '0;
      batch_done <= 1'b0;
    end else begin
      wf_wen     <= lane_live;
      batch_done <= (state == DONE);
      if (lane_live) begin
        wf_addr <= lane_tbaddr;
        wf_din  <= lane_offset;
      end
    end
  end

  // clear beats a same-cycle live lane: the lane is still written but not tracked
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_offset   <= '0;
      reach_end    <= 1'b0;
      reach_tbaddr <= '0;
    end else if (clear) begin
      max_offset   <= '0;
      reach_end    <= 1'b0;
      reach_tbaddr <= '0;
    end else if (lane_live) begin
      if (lane_offset > max_offset) max_offset <= lane_offset;
      if (!reach_end && lane_hits_target) begin
        reach_end    <= 1'b1;
        reach_tbaddr <= lane_tbaddr;
      end
    end
  end

endmodule

// File: tb/tb_extend_reduce.sv
// Scoreboard bench for extend_reduce: stimulus queues expected BRAM writes and
// batch_done pulses with their cycle; a negedge monitor pops and compares them.
module tb_extend_reduce;

  localparam int NE   = 8;
  localparam int LOGT = 9;
  localparam int TBW  = 10;
  localparam int LW   = 2*LOGT+TBW+2;

  typedef struct {
    int cyc;
    int addr;
    int din;
  } wr_t;

  logic               clk;
  logic               rst;
  logic               batch_valid;
  logic [NE*LW-1:0]   batch_data;
  logic [NE-1:0]      lane_valid;
  logic               batch_ready;
  logic [LOGT:0]      target_k;
  logic [LOGT-1:0]    target_offset;
  logic               clear;
  logic               wf_wen;
  logic [TBW-1:0]     wf_addr;
  logic [LOGT-1:0]    wf_din;
  logic [LOGT-1:0]    max_offset;
  logic               reach_end;
  logic [TBW-1:0]     reach_tbaddr;
  logic               batch_done;

  int  n_checks = 0;
  int  n_fails  = 0;
  int  cyc      = 0;
  wr_t wr_q[$];
  int  done_q[$];
  wr_t mon_e;
  int  mon_d;

  extend_reduce dut (
    .clk          (clk),
    .rst          (rst),
    .batch_valid  (batch_valid),
    .batch_data   (batch_data),
    .lane_valid   (lane_valid),
    .batch_ready  (batch_ready),
    .target_k     (target_k),
    .target_offset(target_offset),
    .clear        (clear),
    .wf_wen       (wf_wen),
    .wf_addr      (wf_addr),
    .wf_din       (wf_din),
    .max_offset   (max_offset),
    .reach_end    (reach_end),
    .reach_tbaddr (reach_tbaddr),
    .batch_done   (batch_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  function automatic logic [LW-1:0] mk_lane(input bit v, input int k, input int off, input int tb);
    logic [LW-1:0] w;
    w = {v, (LOGT+1)'(k), LOGT'(off), TBW'(tb)};
    return w;
  endfunction

  // Expected writes: lane i of a batch accepted at edge t appears at t+1+i
  function automatic void push_expect(input logic [NE*LW-1:0] data, input logic [NE-1:0] lv, input int t);
    logic [LW-1:0] w;
    wr_t e;
    for (int i = 0; i < NE; i++) begin
      w = data[i*LW +: LW];
      if (lv[i] && w[LW-1]) begin
        e.cyc  = t + 1 + i;
        e.addr = int'(w[TBW-1:0]);
        e.din  = int'(w[TBW +: LOGT]);
        wr_q.push_back(e);
      end
    end
    done_q.push_back(t + NE + 1);
  endfunction

  // Called on a negedge; returns on the negedge right after the accept edge t
  task automatic applyStimulus(input logic [NE*LW-1:0] data, input logic [NE-1:0] lv, output int t);
    int n = 0;
    while (!batch_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput("ready_before_batch", batch_ready, 1);
    batch_valid = 1'b1;
    batch_data  = data;
    lane_valid  = lv;
    t = cyc + 1;
    push_expect(data, lv, t);
    @(negedge clk);
    batch_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (!batch_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput("idle_timeout", batch_ready, 1);
  endtask

  task automatic check_reset_values();
    checkOutput("rst_batch_ready", batch_ready, 1);
    checkOutput("rst_wf_wen", wf_wen, 0);
    checkOutput("rst_wf_addr", wf_addr, 0);
    checkOutput("rst_wf_din", wf_din, 0);
    checkOutput("rst_max_offset", max_offset, 0);
    checkOutput("rst_reach_end", reach_end, 0);
    checkOutput("rst_reach_tbaddr", reach_tbaddr, 0);
    checkOutput("rst_batch_done", batch_done, 0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (wf_wen) begin
        checkOutput("write_expected", wr_q.size() > 0, 1);
        if (wr_q.size() > 0) begin
          mon_e = wr_q.pop_front();
          checkOutput("write_cycle", cyc, mon_e.cyc);
          checkOutput("write_addr", wf_addr, mon_e.addr);
          checkOutput("write_din", wf_din, mon_e.din);
        end
      end
      if (batch_done) begin
        checkOutput("done_expected", done_q.size() > 0, 1);
        if (done_q.size() > 0) begin
          mon_d = done_q.pop_front();
          checkOutput("done_cycle", cyc, mon_d);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [NE*LW-1:0] d;
    logic [NE*LW-1:0] d2;
    int t;

    rst = 1'b0; batch_valid = 1'b0; batch_data = '0; lane_valid = '0;
    target_k = 10'd3; target_offset = 9'd100; clear = 1'b0;
    #3 rst = 1'b1;
    @(negedge clk);
    check_reset_values();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] test 1: all lanes live");
    for (int i = 0; i < NE; i++) d[i*LW +: LW] = mk_lane(1'b1, 0, 10*i, i);
    applyStimulus(d, 8'hFF, t);
    wait_idle();
    checkOutput("t1_max_offset", max_offset, 70);
    checkOutput("t1_reach_end", reach_end, 0);

    $display("[TB] test 2: sparse lane_valid");
    for (int i = 0; i < NE; i++) d[i*LW +: LW] = mk_lane(1'b1, 0, 5*i, 20+i);
    applyStimulus(d, 8'b1010_0101, t);
    wait_idle();
    checkOutput("t2_max_offset", max_offset, 70);

    $display("[TB] test 3: target reach, first hit wins");
    for (int i = 0; i < NE; i++) d[i*LW +: LW] = mk_lane(1'b1, 1, i, 30+i);
    d[2*LW +: LW] = mk_lane(1'b1, 3, 120, 5);
    d[6*LW +: LW] = mk_lane(1'b1, 3, 200, 9);
    applyStimulus(d, 8'hFF, t);
    repeat (2) @(negedge clk);
    checkOutput("t3_reach_before", reach_end, 0);
    @(negedge clk);
    checkOutput("t3_reach_after_lane2", reach_end, 1);
    checkOutput("t3_tbaddr_after_lane2", reach_tbaddr, 5);
    wait_idle();
    checkOutput("t3_reach_held", reach_end, 1);
    checkOutput("t3_tbaddr_held", reach_tbaddr, 5);
    checkOutput("t3_max_offset", max_offset, 200);

    $display("[TB] test 4: clear during scan");
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    checkOutput("t4_clear_max", max_offset, 0);
    checkOutput("t4_clear_reach", reach_end, 0);
    checkOutput("t4_clear_tbaddr", reach_tbaddr, 0);
    d[0*LW +: LW] = mk_lane(1'b1, 0, 10, 40);
    d[1*LW +: LW] = mk_lane(1'b1, 0, 20, 41);
    d[2*LW +: LW] = mk_lane(1'b1, 0, 50, 42);
    d[3*LW +: LW] = mk_lane(1'b1, 0, 30, 43);
    d[4*LW +: LW] = mk_lane(1'b1, 0, 300, 44);
    d[5*LW +: LW] = mk_lane(1'b1, 0, 40, 45);
    d[6*LW +: LW] = mk_lane(1'b1, 0, 60, 46);
    d[7*LW +: LW] = mk_lane(1'b1, 0, 45, 47);
    applyStimulus(d, 8'hFF, t);
    repeat (4) @(negedge clk);
    checkOutput("t4_max_before_clear", max_offset, 50);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    checkOutput("t4_max_after_clear", max_offset, 0);
    @(negedge clk);
    checkOutput("t4_max_lane5", max_offset, 40);
    wait_idle();
    checkOutput("t4_max_final", max_offset, 60);

    $display("[TB] test 5: back-to-back batch_valid");
    for (int i = 0; i < NE; i++) d[i*LW +: LW] = mk_lane(1'b1, 0, i+1, 100+i);
    for (int i = 0; i < NE; i++) d2[i*LW +: LW] = mk_lane(1'b1, 0, 2*i, 200+i);
    batch_valid = 1'b1;
    batch_data  = d;
    lane_valid  = 8'hFF;
    t = cyc + 1;
    push_expect(d, 8'hFF, t);
    push_expect(d2, 8'hFF, t + NE + 2);
    @(negedge clk);
    batch_data = d2;
    for (int j = 0; j <= NE; j++) begin
      checkOutput("t5_ready_low", batch_ready, 0);
      @(negedge clk);
    end
    checkOutput("t5_ready_high", batch_ready, 1);
    @(negedge clk);
    batch_valid = 1'b0;
    checkOutput("t5_ready_low_b", batch_ready, 0);
    wait_idle();

    $display("[TB] test 6: reset mid-scan");
    for (int i = 0; i < NE; i++) d[i*LW +: LW] = mk_lane(1'b1, 0, 3*i, 250+i);
    applyStimulus(d, 8'hFF, t);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    wr_q.delete();
    done_q.delete();
    #1;
    check_reset_values();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    checkOutput("t6_ready_after_rst", batch_ready, 1);
    for (int i = 0; i < NE; i++) d[i*LW +: LW] = mk_lane(1'b1, 0, 7*i, 300+i);
    applyStimulus(d, 8'hFF, t);
    wait_idle();
    checkOutput("t6_max_offset", max_offset, 49);

    repeat (3) @(negedge clk);
    checkOutput("writes_drained", wr_q.size(), 0);
    checkOutput("dones_drained", done_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
